sha256_padder: RTL and testbench

Upstream message-formatting stage for the SHA-256 compression core. Accepts an arbitrary-length byte stream and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. Emits 512-bit blocks over a valid/ready handshake, flagged first/final, so integration glue can drive the core's `start`/`first_run` inputs.

---
 rtl/sha256_pkg.sv | 40 ++++
 rtl/sha256_byte_buf.sv | 45 ++++
 rtl/sha256_padder.sv | 127 ++++++++++++
 tb/tb_sha256_padder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, block geometry, and the
// compression core's initial hash values and round constants.
package sha256_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        PAD    = 2'd1,
        LEN    = 2'd2,
        EMIT   = 2'd3
    } pad_state_t;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned LEN_OFFSET  = 56;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;

    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROUND [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_byte_buf.sv
// 64-byte block buffer with single-byte write, tail clear and length insert.
// Priority per byte: length insert, then byte write, then clear.
module sha256_byte_buf
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [5:0]   wr_idx,
    input  logic [7:0]   wr_data,
    input  logic         clr_en,
    input  logic [5:0]   clr_from,
    input  logic         len_en,
    input  logic [63:0]  len_val,
    output logic [511:0] block_out
);

    logic [7:0] mem [BLOCK_BYTES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
                if (len_en && i >= LEN_OFFSET) begin
                    mem[i] <= len_val[8*(63-i) +: 8];
                end else if (wr_en && wr_idx == 6'(i)) begin
                    mem[i] <= wr_data;
                end else if (clr_en && 6'(i) >= clr_from) begin
                    mem[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        block_out = '0;
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
            block_out[511-8*i -: 8] = mem[i];
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: byte stream in, 512-bit padded blocks out over
// valid/ready, tagged first/final for the compression core.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    output logic         block_first,
    output logic         block_final,
    input  logic         block_ready
);

    pad_state_t  state;
    pad_state_t  nxt;
    logic [5:0]  idx;
    logic [63:0] bitlen;
    logic        first_pend;
    logic        final_q;

    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr_en;
    logic [5:0]  clr_from;
    logic        len_en;

    assign in_ready = (state == ACCEPT);

    // PAD writes the marker at idx and clears the tail from idx; the marker
    // wins over the clear inside the buffer, LEN clears everything.
    always_comb begin
        wr_en    = (state == ACCEPT && in_valid) || (state == PAD);
        wr_data  = (state == PAD) ? PAD_BYTE : in_data;
        clr_en   = (state == PAD) || (state == LEN);
        clr_from = (state == LEN) ? 6'd0 : idx;
        len_en   = (state == LEN) || (state == PAD && idx <= 6'd55);
    end

    sha256_byte_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (idx),
        .wr_data   (wr_data),
        .clr_en    (clr_en),
        .clr_from  (clr_from),
        .len_en    (len_en),
        .len_val   (bitlen),
        .block_out (block_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCEPT;
            nxt         <= ACCEPT;
            idx         <= '0;
            bitlen      <= '0;
            first_pend  <= 1'b1;
            final_q     <= 1'b0;
            block_valid <= 1'b0;
            block_first <= 1'b0;
            block_final <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (in_valid) begin
                        bitlen <= bitlen + 64'd8;
                        idx    <= idx + 6'd1;
                        if (idx == 6'd63) begin
                            state       <= EMIT;
                            final_q     <= 1'b0;
                            nxt         <= in_last ? PAD : ACCEPT;
                            block_valid <= 1'b1;
                            block_first <= first_pend;
                            block_final <= 1'b0;
                        end else if (in_last) begin
                            state <= PAD;
                        end
                    end
                end
                PAD: begin
                    state       <= EMIT;
                    block_valid <= 1'b1;
                    block_first <= first_pend;
                    if (idx <= 6'd55) begin
                        final_q     <= 1'b1;
                        block_final <= 1'b1;
                    end else begin
                        final_q     <= 1'b0;
                        nxt         <= LEN;
                        block_final <= 1'b0;
                    end
                end
                LEN: begin
                    state       <= EMIT;
                    final_q     <= 1'b1;
                    block_valid <= 1'b1;
                    block_first <= first_pend;
                    block_final <= 1'b1;
                end
                EMIT: begin
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        block_first <= 1'b0;
                        block_final <= 1'b0;
                        idx         <= '0;
                        first_pend  <= 1'b0;
                        if (final_q) begin
                            bitlen     <= '0;
                            first_pend <= 1'b1;
                            state      <= ACCEPT;
                        end else begin
                            state <= nxt;
                        end
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder against a byte-queue padding model.
module tb_sha256_padder;

    typedef logic [7:0] bq_t [$];
    typedef struct packed { logic [7:0] d; logic l; } sb_t;
    typedef struct packed { logic [511:0] data; logic first; logic fin; } blk_t;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_first;
    logic         block_final;
    logic         block_ready = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    sb_t  stream_q [$];
    blk_t exp_q [$];
    logic [511:0] last_blk;
    logic         last_first;
    logic         last_fin;

    sha256_padder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_first (block_first),
        .block_final (block_final),
        .block_ready (block_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t mk(input int n, input int kind);
        bq_t m;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0: m.push_back(8'h00);
                1: m.push_back(8'($urandom));
                default: m.push_back(8'(i));
            endcase
        end
        return m;
    endfunction

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit bit length; cut in 64s.
    task automatic add_msg(input bq_t m);
        logic [7:0]  p [$];
        logic [63:0] bl;
        blk_t        b;
        int          nb;
        for (int i = 0; i < m.size(); i++) begin
            stream_q.push_back(sb_t'{d: m[i], l: (i == m.size() - 1)});
        end
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int k = 0; k < 8; k++) p.push_back(bl[63-8*k -: 8]);
        nb = p.size() / 64;
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[64*bi + j];
            b.first = (bi == 0);
            b.fin   = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    // mode 0: always ready; 1: random gaps on both sides; 2: 10-cycle stall per block
    task automatic run(input int mode);
        int           cyc;
        int           hold;
        logic         prev_stall;
        logic [511:0] prev_out;
        logic         prev_first;
        logic         prev_fin;
        blk_t         e;
        cyc = 0;
        hold = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        prev_first = 1'b0;
        prev_fin = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                check("timeout_blocks_left", 512'(exp_q.size()), 512'd0);
                exp_q.delete();
                stream_q.delete();
                break;
            end
            if (stream_q.size() > 0 && (mode != 1 || $urandom_range(3) != 0)) begin
                in_valid = 1'b1;
                in_data  = stream_q[0].d;
                in_last  = stream_q[0].l;
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'b0;
            end
            case (mode)
                0: block_ready = 1'b1;
                1: block_ready = 1'($urandom_range(1));
                default: begin
                    if (block_valid && hold < 10) begin
                        block_ready = 1'b0;
                        hold++;
                    end else begin
                        block_ready = 1'b1;
                    end
                end
            endcase
            #1;
            if (prev_stall) begin
                check("stall_valid", 512'(block_valid), 512'd1);
                check("stall_data", block_out, prev_out);
                check("stall_flags", 512'({block_first, block_final}), 512'({prev_first, prev_fin}));
            end
            if (block_valid) check("in_ready_in_emit", 512'(in_ready), 512'd0);
            if (in_valid && in_ready) void'(stream_q.pop_front());
            if (block_valid && block_ready) begin
                e = exp_q.pop_front();
                check("block_out", block_out, e.data);
                check("block_first", 512'(block_first), 512'(e.first));
                check("block_final", 512'(block_final), 512'(e.fin));
                last_blk   = block_out;
                last_first = block_first;
                last_fin   = block_final;
                hold = 0;
            end
            prev_stall = block_valid && !block_ready;
            prev_out   = block_out;
            prev_first = block_first;
            prev_fin   = block_final;
        end
        check("bytes_left", 512'(stream_q.size()), 512'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        block_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 512'(block_valid), 512'd0);
        check({tag, "_flags"}, 512'({block_first, block_final}), 512'd0);
        check({tag, "_data"}, block_out, 512'd0);
        check({tag, "_in_ready"}, 512'(in_ready), 512'd1);
    endtask

    task automatic send_bytes(input int n, input logic last_on_end);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            in_last  = last_on_end && (i == n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        bq_t abc;
        int  waited;
        abc = '{8'h61, 8'h62, 8'h63};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        add_msg(abc);
        run(0);
        check("abc_direct", last_blk, ABC_BLK);
        check("abc_flags", 512'({last_first, last_fin}), 512'b11);

        add_msg(mk(55, 0));
        run(0);
        add_msg(mk(56, 2));
        run(0);
        add_msg(mk(64, 2));
        run(0);

        add_msg(mk(10, 1));
        add_msg(mk(70, 1));
        run(2);

        for (int t = 0; t < 6; t++) add_msg(mk(int'($urandom_range(200, 1)), 1));
        add_msg(mk(63, 1));
        add_msg(mk(119, 1));
        add_msg(mk(128, 1));
        run(1);

        send_bytes(30, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_msg");
        @(negedge clk);
        rst_n = 1'b1;
        add_msg(abc);
        run(0);
        check("abc_after_reset", last_blk, ABC_BLK);
        check("abc_after_reset_flags", 512'({last_first, last_fin}), 512'b11);

        send_bytes(5, 1'b1);
        waited = 0;
        while (!block_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("emit_reached", 512'(block_valid), 512'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_emit");
        @(negedge clk);
        rst_n = 1'b1;
        add_msg(mk(20, 1));
        run(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
